key_event_classifier: RTL and testbench



---
 rtl/key_event_classifier.sv | 136 +++++++++++++
 tb/tb_key_event_classifier.sv | 129 ++++++++++++
 2 files changed

// File: rtl/key_event_classifier.sv
// Classifies a debounced key level into short, double, long and auto-repeat events.
// All timing comes from a millisecond prescaler that restarts on every state change.
module key_event_classifier #(
  parameter int unsigned CLK_PER_MS = 1000,
  parameter int unsigned LONG_MS    = 1000,
  parameter int unsigned DBL_GAP_MS = 250,
  parameter int unsigned REPEAT_MS  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int unsigned MAX_A  = (LONG_MS > DBL_GAP_MS) ? LONG_MS : DBL_GAP_MS;
  localparam int unsigned MAX_MS = (MAX_A > REPEAT_MS) ? MAX_A : REPEAT_MS;
  localparam int unsigned PRE_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int unsigned MS_W   = $clog2(MAX_MS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_PRESS2,
    S_LONG_HOLD
  } state_e;

  state_e            state_q;
  logic [PRE_W-1:0]  pre_q;
  logic [MS_W-1:0]   ms_q;
  logic              short_q;
  logic              double_q;
  logic              long_q;
  logic              repeat_q;
  logic              busy_q;

  logic              pre_wrap_c;
  logic              long_hit_c;
  logic              gap_hit_c;
  logic              rep_hit_c;
  logic [PRE_W-1:0]  pre_inc_c;
  logic [MS_W-1:0]   ms_inc_c;

  // Timeout fires on the last cycle of the interval, i.e. E = N*CLK_PER_MS-1.
  assign pre_wrap_c = (pre_q == PRE_W'(CLK_PER_MS - 1));
  assign long_hit_c = pre_wrap_c && (ms_q == MS_W'(LONG_MS - 1));
  assign gap_hit_c  = pre_wrap_c && (ms_q == MS_W'(DBL_GAP_MS - 1));
  assign rep_hit_c  = pre_wrap_c && (ms_q == MS_W'(REPEAT_MS - 1));
  assign pre_inc_c  = pre_wrap_c ? '0 : pre_q + PRE_W'(1);
  assign ms_inc_c   = pre_wrap_c ? ms_q + MS_W'(1) : ms_q;

  // Counters default to clear (every transition restarts them); states that time something count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      ms_q     <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pre_q    <= '0;
      ms_q     <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key) begin
            state_q <= S_PRESS1;
            busy_q  <= 1'b1;
          end
        end
        S_PRESS1: begin
          if (!key) begin
            state_q <= S_GAP;
          end else if (long_hit_c) begin
            state_q <= S_LONG_HOLD;
            long_q  <= 1'b1;
          end else begin
            pre_q <= pre_inc_c;
            ms_q  <= ms_inc_c;
          end
        end
        S_GAP: begin
          if (key) begin
            state_q <= S_PRESS2;
          end else if (gap_hit_c) begin
            state_q <= S_IDLE;
            short_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            pre_q <= pre_inc_c;
            ms_q  <= ms_inc_c;
          end
        end
        S_PRESS2: begin
          if (!key) begin
            state_q  <= S_IDLE;
            double_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        S_LONG_HOLD: begin
          if (!key) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (rep_hit_c) begin
            repeat_q <= 1'b1;
          end else begin
            pre_q <= pre_inc_c;
            ms_q  <= ms_inc_c;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign short_pulse  = short_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier: segment table of held inputs plus a third-press sequence.
module tb_key_event_classifier;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_S    = 4'b1000;
  localparam logic [3:0] P_D    = 4'b0100;
  localparam logic [3:0] P_L    = 4'b0010;
  localparam logic [3:0] P_R    = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b0;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Inputs held for n edges; pulses must be P_NONE except 'pulse' on the last edge.
  typedef struct {
    logic       rst;
    logic       key;
    int         n;
    logic [3:0] pulse;
    logic       busy;
  } seg_t;

  seg_t segs[$];

  key_event_classifier #(
    .CLK_PER_MS(4),
    .LONG_MS   (10),
    .DBL_GAP_MS(5),
    .REPEAT_MS (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic k, input int n,
                              input logic [3:0] p, input logic b);
    seg_t s;
    s.rst = r; s.key = k; s.n = n; s.pulse = p; s.busy = b;
    segs.push_back(s);
  endfunction

  task automatic step(input logic r, input logic k);
    rst = r;
    key = k;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d] at %0t: got %b expected %b", name, idx, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {short_pulse, double_pulse, long_pulse, repeat_pulse};
  endfunction

  initial begin
    // reset with key toggling
    add(1, 1, 1, P_NONE, 0); add(1, 0, 1, P_NONE, 0); add(1, 1, 1, P_NONE, 0);
    // release reset with key held: PRESS1 at once, long at +40, repeats at +52/+64/+76
    add(0, 1, 1, P_NONE, 1); add(0, 1, 40, P_L, 1);
    add(0, 1, 12, P_R, 1);   add(0, 1, 12, P_R, 1); add(0, 1, 12, P_R, 1);
    add(0, 1, 3, P_NONE, 1); add(0, 0, 1, P_NONE, 0); add(0, 0, 30, P_NONE, 0);
    // short press: short 20 cycles after release
    add(0, 1, 8, P_NONE, 1); add(0, 0, 1, P_NONE, 1); add(0, 0, 20, P_S, 0);
    add(0, 0, 10, P_NONE, 0);
    // double press
    add(0, 1, 8, P_NONE, 1); add(0, 0, 10, P_NONE, 1); add(0, 1, 6, P_NONE, 1);
    add(0, 0, 1, P_D, 0);    add(0, 0, 25, P_NONE, 0);
    // release exactly on PRESS1 E=39: no long, short follows
    add(0, 1, 40, P_NONE, 1); add(0, 0, 1, P_NONE, 1); add(0, 0, 20, P_S, 0);
    add(0, 0, 5, P_NONE, 0);
    // re-press exactly on GAP E=19: double path
    add(0, 1, 8, P_NONE, 1); add(0, 0, 20, P_NONE, 1); add(0, 1, 5, P_NONE, 1);
    add(0, 0, 1, P_D, 0);    add(0, 0, 5, P_NONE, 0);
    // reset during LONG_HOLD spanning the next repeat, then a fresh long press
    add(0, 1, 41, P_L, 1); add(0, 1, 12, P_R, 1); add(0, 1, 5, P_NONE, 1);
    add(1, 1, 10, P_NONE, 0);
    add(0, 1, 41, P_L, 1); add(0, 0, 1, P_NONE, 0); add(0, 0, 5, P_NONE, 0);

    #2;
    foreach (segs[i]) begin
      for (int c = 0; c < segs[i].n; c++) begin
        step(segs[i].rst, segs[i].key);
        chk("pulses", i, pulses(), (c == segs[i].n - 1) ? segs[i].pulse : P_NONE);
      end
      chk("busy", i, {3'b000, busy}, {3'b000, segs[i].busy});
    end

    // third press in the double_pulse cycle starts a new gesture immediately
    for (int c = 0; c < 3; c++) step(0, 1);
    for (int c = 0; c < 3; c++) step(0, 0);
    for (int c = 0; c < 3; c++) step(0, 1);
    step(0, 0);
    chk("third_dbl", 0, pulses(), P_D);
    step(0, 1);
    chk("third_busy", 0, {3'b000, busy}, 4'b0001);
    chk("third_quiet", 0, pulses(), P_NONE);
    for (int c = 0; c < 39; c++) begin
      step(0, 1);
      chk("third_hold", c, pulses(), P_NONE);
    end
    step(0, 1);
    chk("third_long", 0, pulses(), P_L);
    step(0, 0);
    chk("third_idle", 0, {3'b000, busy}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
